// File: rtl/star_row_mapper_pkg.sv
// Shared definitions for the star row mapper and its address translator.
//
// Contents:
//   - image geometry (MAX_X x MAX_Y pixels, one colour word per pixel)
//   - coordinate, address and colour widths
//   - brightness threshold and the isBright helper
//   - state encoding for the row-mapping FSM
package star_row_mapper_pkg;

  // Image geometry: 160 columns by 120 rows, stored row-major in the RAM.
  localparam int MAX_X = 160;
  localparam int MAX_Y = 120;

  // Field widths used on every port of this slice.
  localparam int xSz    = 8;
  localparam int ySz    = 7;
  localparam int addrSz = 15;
  localparam int colSz  = 3;

  // A pixel counts as part of a star when its colour is strictly above this.
  localparam int THRESHOLD = 0;

  // Last valid row; the downward walk must never read past it.
  localparam logic [ySz-1:0] LAST_ROW = ySz'(MAX_Y - 1);

  // Row-mapper FSM states. Each RAM read costs an RD cycle (address out)
  // followed by a CHK cycle (data back).
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UP_RD  = 3'd1,
    UP_CHK = 3'd2,
    DN_RD  = 3'd3,
    DN_CHK = 3'd4,
    DONE   = 3'd5
  } mapState_t;

  // Unsigned brightness test shared by everything that reads pixels.
  function automatic logic isBright(input logic [colSz-1:0] colour);
    return colour > colSz'(THRESHOLD);
  endfunction

endpackage

// File: rtl/vga_address_translator.sv
// Combinational (x, y) -> linear RAM address for the 160x120 image.
//
// Ports:
//   x        in   xSz     column, 0..159
//   y        in   ySz     row, 0..119
//   address  out  addrSz  y*160 + x
//
// The multiply by 160 is done as (y<<7) + (y<<5). With y <= 119 and
// x <= 159 the largest result is 19199, which fits in 15 bits, so the
// zero-extended sum never needs a carry beyond addrSz.
module vga_address_translator
  import star_row_mapper_pkg::*;
(
  input  logic [xSz-1:0]    x,
  input  logic [ySz-1:0]    y,
  output logic [addrSz-1:0] address
);

  logic [addrSz-1:0] yExt;
  logic [addrSz-1:0] xExt;

  assign yExt = addrSz'(y);
  assign xExt = addrSz'(x);

  // Shift-and-add form of y*160 keeps this free of a real multiplier.
  assign address = (yExt << 7) + (yExt << 5) + xExt;

endmodule

// File: rtl/star_row_mapper.sv
// Star row mapper: after the scan FSM finds a bright seed pixel, walk the
// seed's column upward and then downward to find the first and last bright
// rows of the star, then pulse topBottomFound for one cycle.
//
// Ports:
//   clk             in   1       system clock, rising edge
//   reset           in   1       synchronous, active-high
//   goMapRows       in   1       start pulse, seed sampled in the same cycle
//   xSeed           in   xSz     seed column
//   ySeed           in   ySz     seed row (seed pixel is known bright)
//   pixVal          in   colSz   RAM data, valid the cycle after rdAddress
//   rdAddress       out  addrSz  RAM read address for (seed column, rdRow)
//   rdReq           out  1       rdAddress is meaningful this cycle
//   yTop            out  ySz     topmost bright row of the seed's run
//   yBottom         out  ySz     bottommost bright row of the seed's run
//   busy            out  1       high in every state except IDLE
//   topBottomFound  out  1       one-cycle pulse, yTop/yBottom valid from here
module star_row_mapper
  import star_row_mapper_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              goMapRows,
  input  logic [xSz-1:0]    xSeed,
  input  logic [ySz-1:0]    ySeed,
  input  logic [colSz-1:0]  pixVal,
  output logic [addrSz-1:0] rdAddress,
  output logic              rdReq,
  output logic [ySz-1:0]    yTop,
  output logic [ySz-1:0]    yBottom,
  output logic              busy,
  output logic              topBottomFound
);

  mapState_t      state;
  logic [xSz-1:0] xLat;
  // Row currently being addressed. During the upward walk it doubles as the
  // walking counter; during the downward walk it is always yBottom+1.
  logic [ySz-1:0] rdRow;

  // The translator works from registered values only, so rdAddress is
  // stable for the whole RD cycle and is 0 straight out of reset.
  vga_address_translator addrXlate (
    .x       (xLat),
    .y       (rdRow),
    .address (rdAddress)
  );

  // Single FSM with registered outputs. rdReq and topBottomFound are
  // computed on the transition INTO the state that needs them, which is why
  // every path into DN_RD decides up front whether a read will happen: a
  // DN_RD whose yBottom is already the last row just falls through to DONE
  // without asserting rdReq.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      xLat           <= '0;
      rdRow          <= '0;
      yTop           <= '0;
      yBottom        <= '0;
      rdReq          <= 1'b0;
      busy           <= 1'b0;
      topBottomFound <= 1'b0;
    end else begin
      rdReq          <= 1'b0;
      topBottomFound <= 1'b0;

      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (goMapRows) begin
            xLat    <= xSeed;
            yTop    <= ySeed;
            yBottom <= ySeed;
            busy    <= 1'b1;
            if (ySeed == '0) begin
              // Nothing above row 0, so start straight on the way down.
              state <= DN_RD;
              rdRow <= ySeed + 1'b1;
              rdReq <= (ySeed != LAST_ROW);
            end else begin
              state <= UP_RD;
              rdRow <= ySeed - 1'b1;
              rdReq <= 1'b1;
            end
          end
        end

        UP_RD: begin
          state <= UP_CHK;
        end

        UP_CHK: begin
          if (isBright(pixVal)) begin
            yTop <= rdRow;
            if (rdRow == '0) begin
              state <= DN_RD;
              rdRow <= yBottom + 1'b1;
              rdReq <= (yBottom != LAST_ROW);
            end else begin
              state <= UP_RD;
              rdRow <= rdRow - 1'b1;
              rdReq <= 1'b1;
            end
          end else begin
            state <= DN_RD;
            rdRow <= yBottom + 1'b1;
            rdReq <= (yBottom != LAST_ROW);
          end
        end

        DN_RD: begin
          if (yBottom == LAST_ROW) begin
            state          <= DONE;
            topBottomFound <= 1'b1;
          end else begin
            state <= DN_CHK;
          end
        end

        DN_CHK: begin
          if (isBright(pixVal)) begin
            // rdRow already holds yBottom+1, the row just confirmed bright.
            yBottom <= rdRow;
            state   <= DN_RD;
            rdRow   <= rdRow + 1'b1;
            rdReq   <= (rdRow != LAST_ROW);
          end else begin
            state          <= DONE;
            topBottomFound <= 1'b1;
          end
        end

        DONE: begin
          // A goMapRows arriving now is dropped; the caller re-pulses in IDLE.
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
